text_pixel_gen: RTL and testbench
=================================

# text_pixel_gen

Text-mode pixel generator that reads the character ROM. For each active pixel it fetches the character code from the text buffer, then issues the glyph-row address to the character ROM. It serializes the returned 8-bit glyph row into a 1-bit pixel stream, with sync and data-enable delayed to match. It sits between the VGA timing generator and the output DAC/pin stage.

## Interface
Parameters:
- COLS, 80, text columns per row
- ROWS, 40, text rows per frame
- CELL_H, 12, scanlines per character cell
- FONT_H, 9, glyph rows stored in ROM (rows 0..FONT_H-1)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- pix_ce  in  1  pixel enable; all pipeline state advances only when high
- de_in / hs_in / vs_in  in  1 each  timing-generator data-enable / hsync / vsync
- hcount  in  10  pixel column within line (valid when de_in)
- tram_addr  out  12  text-buffer address = row*COLS + col
- tram_data  in  8  [7] invert attribute, [6:0] character code
- rom_ad  out  11  character ROM address = {glyph_row[3:0], code[6:0]}
- rom_ce  out  1  ROM clock enable (= pix_ce)
- rom_dout  in  8  glyph row, bit 7 = leftmost pixel
- pix  out  1  pixel out (1 = foreground)
- de_out / hs_out / vs_out  out  1 each  delayed timing signals
- cursor_col  in  7, cursor_row  in  6  cursor cell (only with TEXT_CURSOR_EN)

## Operation
- Line tracking:
  - vs_in high: text_row = 0, cell_line = 0, row_base = 0.
  - Falling edge of de_in (sampled on pix_ce): cell_line increments.
  - At cell_line == CELL_H-1, cell_line wraps to 0, text_row increments, and row_base increases by COLS.
  - No multiplier or divider.
- col = hcount[9:3], bit index = hcount[2:0].
- In-area: de_in && col < COLS && text_row < ROWS.
- Pipeline, one stage per pix_ce:
  - S1: register tram_addr = row_base + col, plus in-area, bit index, cell_line, de/hs/vs.
  - S2: tram_data valid. Register rom_ad = {cell_line[3:0], tram_data[6:0]} and the invert bit.
  - S3: rom_dout valid. Select bit 7 - idx.
    - Force the bit to 0 if cell_line ≥ FONT_H.
    - XOR with invert.
    - Force 0 if not in-area.
  - S4: registered outputs pix, de_out, hs_out, vs_out.
- External RAM and ROM are synchronous, enabled by pix_ce. Data is returned on the pix_ce following the address.
- Outputs while de_in is low: pix = 0, and sync is still delayed.

## Timing
- Latency: 4 pix_ce cycles from hcount/de_in/hs_in/vs_in to pix/de_out/hs_out/vs_out, identical for all four.
- pix_ce low: every register holds and tram_addr/rom_ad are unchanged. Any stall length is legal.
- Reset values:
  - pix, de_out, hs_out, vs_out, tram_addr, rom_ad = 0.
  - Counters = 0.
  - Blink phase = off.
- Reset mid-frame: outputs return to 0 immediately (async). Line tracking resyncs at the next vs_in.
- Back-to-back lines are handled: de falling edge and vs_in in the same pix_ce cycle resolves with vs_in winning.
- text_row saturates at ROWS; cells beyond it output 0.

## Configuration
- TEXT_CURSOR_EN defined:
  - A 5-bit frame counter increments on each vs_in rising edge; the blink phase is bit 4 (16 frames on, 16 off).
  - When the phase is on, the cell matches cursor_col/cursor_row, and cell_line ≥ CELL_H-2, pix is forced to 1 after the invert.
  - The cursor ports exist.
- TEXT_CURSOR_EN undefined: no frame counter and no cursor ports; pix is the glyph path only.

## Structure
- Package text_pkg: COLS/ROWS/CELL_H/FONT_H defaults, address widths, tram_data field positions (INV_BIT = 7, CODE_W = 7).
- Sub-module glyph_bit_sel: S3 combinational bit select, FONT_H blanking, invert and cursor overlay. Shift/line counters stay in the top.

## Test plan
- Reset asserted mid-line with de_in = 1: pix/de_out/hs_out/vs_out = 0 in the same cycle, and stay 0 until 4 pix_ce after release.
- ROM model returns 0xA5 at {row 2, code 0x41}, tram_data = 0x41 at addr 0, line 2, pix_ce = 1 continuous: pix over hcount 0..7 = 1,0,1,0,0,1,0,1, appearing 4 cycles later.
- Same setup with tram_data = 0xC1: pix = 0,1,0,1,1,0,1,0.
- Line 12, col 3: tram_addr = 83 and rom_ad row field = 0. Line 10 (cell_line 10 ≥ FONT_H): pix = 0 regardless of rom_dout.
- Toggle pix_ce 1-0-0-0-1 during active line: outputs and addresses hold over the 3 low cycles, and the sequence resumes without skipping a pixel.
- TEXT_CURSOR_EN with cursor (0,0), after 16 vs_in pulses: pix = 1 on lines 10–11, hcount 0..7. After 32 pulses, pix follows the glyph.

Source files
------------

// File: rtl/text_pixel_gen_pkg.sv
// Shared constants and types for the text-mode pixel generator.
package text_pkg;

  localparam int unsigned COLS_DEF   = 80;
  localparam int unsigned ROWS_DEF   = 40;
  localparam int unsigned CELL_H_DEF = 12;
  localparam int unsigned FONT_H_DEF = 9;

  localparam int unsigned TRAM_AW = 12;
  localparam int unsigned ROM_AW  = 11;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 6;
  localparam int unsigned LINE_W  = 4;
  localparam int unsigned IDX_W   = 3;

  // tram_data layout: [7] invert attribute, [6:0] character code
  localparam int unsigned INV_BIT = 7;
  localparam int unsigned CODE_W  = 7;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

endpackage

// File: rtl/text_pixel_gen_if.sv
// Text-buffer RAM and character-ROM bus; master is the pixel generator.
interface text_pixel_gen_if;
  import text_pkg::*;

  logic [TRAM_AW-1:0] tram_addr;
  logic [7:0]         tram_data;
  logic [ROM_AW-1:0]  rom_ad;
  logic               rom_ce;
  logic [7:0]         rom_dout;

  modport master (
    output tram_addr, rom_ad, rom_ce,
    input  tram_data, rom_dout
  );

  modport slave (
    input  tram_addr, rom_ad, rom_ce,
    output tram_data, rom_dout
  );
endinterface

// File: rtl/text_pixel_gen_glyph_bit_sel.sv
// Picks one pixel out of a glyph row, blanks rows past the font height,
// applies the invert attribute, the cursor overlay and the in-area mask.
module glyph_bit_sel
  import text_pkg::*;
#(
  parameter int unsigned FONT_H = FONT_H_DEF
) (
  input  logic [7:0]        i_glyph,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_inv,
  input  logic              i_inarea,
  input  logic              i_cursor,
  output logic              o_bit
);
  localparam logic [LINE_W:0] FONT_H_L = (LINE_W+1)'(FONT_H);

  logic w_glyph_bit;

  // Glyph bit (bit 7 is leftmost), then invert, cursor, area mask in that order
  always_comb begin
    w_glyph_bit = i_glyph[3'd7 - i_idx];
    if ({1'b0, i_line} >= FONT_H_L) w_glyph_bit = 1'b0;
    o_bit = w_glyph_bit ^ i_inv;
    if (i_cursor) o_bit = 1'b1;
    if (!i_inarea) o_bit = 1'b0;
  end
endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: text RAM -> char ROM -> 1-bit pixel stream,
// with de/hs/vs delayed by the same four pix_ce stages.
// Optional blinking cursor overlay: define TEXT_CURSOR_EN.
module text_pixel_gen
  import text_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned CELL_H = CELL_H_DEF,
  parameter int unsigned FONT_H = FONT_H_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pix_ce,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [9:0]       hcount,
  text_pixel_gen_if.master mem,
  output logic             pix,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
`ifdef TEXT_CURSOR_EN
  ,
  input  logic [COL_W-1:0] cursor_col,
  input  logic [ROW_W-1:0] cursor_row
`endif
);
  localparam logic [ROW_W-1:0]   ROWS_L    = ROW_W'(ROWS);
  localparam logic [COL_W-1:0]   COLS_L    = COL_W'(COLS);
  localparam logic [TRAM_AW-1:0] COLS_A    = TRAM_AW'(COLS);
  localparam logic [LINE_W-1:0]  LAST_LINE = LINE_W'(CELL_H - 1);

  // line tracking
  logic [ROW_W-1:0]   r_text_row;
  logic [LINE_W-1:0]  r_cell_line;
  logic [TRAM_AW-1:0] r_row_base;
  logic               r_de_prev;

  // pipeline
  logic               r1_inarea, r1_cur;
  logic [IDX_W-1:0]   r1_idx;
  logic [LINE_W-1:0]  r1_line;
  sync_t              r1_sync;
  logic               r2_inarea, r2_cur, r2_inv;
  logic [IDX_W-1:0]   r2_idx;
  logic [LINE_W-1:0]  r2_line;
  sync_t              r2_sync;
  logic               r3_bit;
  sync_t              r3_sync;

  logic [COL_W-1:0]   w_col;
  logic [IDX_W-1:0]   w_idx;
  logic               w_inarea;
  logic               w_cur_hit;
  logic               w_bit;
  sync_t              w_sync;

  assign w_col    = hcount[9:3];
  assign w_idx    = hcount[2:0];
  assign w_inarea = de_in && (w_col < COLS_L) && (r_text_row < ROWS_L);
  assign w_sync   = {de_in, hs_in, vs_in};
  assign mem.rom_ce = pix_ce;

`ifdef TEXT_CURSOR_EN
  localparam logic [LINE_W-1:0] CUR_LINE = LINE_W'(CELL_H - 2);

  logic [4:0] r_frame;
  logic       r_vs_prev;

  // Frame counter on vs rising edges; bit 4 is the blink phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame   <= '0;
      r_vs_prev <= 1'b0;
    end else if (pix_ce) begin
      r_vs_prev <= vs_in;
      if (vs_in && !r_vs_prev) r_frame <= r_frame + 1'b1;
    end
  end

  assign w_cur_hit = r_frame[4] && (w_col == cursor_col) &&
                     (r_text_row == cursor_row) && (r_cell_line >= CUR_LINE);
`else
  assign w_cur_hit = 1'b0;
`endif

  // Scanline/text-row tracking; vs wins over a coincident de falling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_text_row  <= '0;
      r_cell_line <= '0;
      r_row_base  <= '0;
      r_de_prev   <= 1'b0;
    end else if (pix_ce) begin
      r_de_prev <= de_in;
      if (vs_in) begin
        r_text_row  <= '0;
        r_cell_line <= '0;
        r_row_base  <= '0;
      end else if (r_de_prev && !de_in) begin
        if (r_cell_line == LAST_LINE) begin
          r_cell_line <= '0;
          if (r_text_row != ROWS_L) begin
            r_text_row <= r_text_row + 1'b1;
            r_row_base <= r_row_base + COLS_A;
          end
        end else begin
          r_cell_line <= r_cell_line + 1'b1;
        end
      end
    end
  end

  // S1: text-buffer address plus side-band
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem.tram_addr <= '0;
      r1_inarea     <= 1'b0;
      r1_cur        <= 1'b0;
      r1_idx        <= '0;
      r1_line       <= '0;
      r1_sync       <= '0;
    end else if (pix_ce) begin
      mem.tram_addr <= r_row_base + TRAM_AW'(w_col);
      r1_inarea     <= w_inarea;
      r1_cur        <= w_cur_hit && w_inarea;
      r1_idx        <= w_idx;
      r1_line       <= r_cell_line;
      r1_sync       <= w_sync;
    end
  end

  // S2: glyph-row address from the returned character code
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem.rom_ad <= '0;
      r2_inv     <= 1'b0;
      r2_inarea  <= 1'b0;
      r2_cur     <= 1'b0;
      r2_idx     <= '0;
      r2_line    <= '0;
      r2_sync    <= '0;
    end else if (pix_ce) begin
      mem.rom_ad <= {r1_line, mem.tram_data[CODE_W-1:0]};
      r2_inv     <= mem.tram_data[INV_BIT];
      r2_inarea  <= r1_inarea;
      r2_cur     <= r1_cur;
      r2_idx     <= r1_idx;
      r2_line    <= r1_line;
      r2_sync    <= r1_sync;
    end
  end

  glyph_bit_sel #(.FONT_H(FONT_H)) u_bit_sel (
    .i_glyph  (mem.rom_dout),
    .i_idx    (r2_idx),
    .i_line   (r2_line),
    .i_inv    (r2_inv),
    .i_inarea (r2_inarea),
    .i_cursor (r2_cur),
    .o_bit    (w_bit)
  );

  // S3: capture the selected pixel; with both memories answering one
  // pix_ce after their address, this stage keeps the total at four
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r3_bit  <= 1'b0;
      r3_sync <= '0;
    end else if (pix_ce) begin
      r3_bit  <= w_bit;
      r3_sync <= r2_sync;
    end
  end

  // S4: registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix    <= 1'b0;
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else if (pix_ce) begin
      pix    <= r3_bit;
      de_out <= r3_sync.de;
      hs_out <= r3_sync.hs;
      vs_out <= r3_sync.vs;
    end
  end
endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen (cursor checks when TEXT_CURSOR_EN is defined).
module tb_text_pixel_gen;
  import text_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pix_ce, de_in, hs_in, vs_in;
  logic [9:0] hcount;
  logic       pix, de_out, hs_out, vs_out;
`ifdef TEXT_CURSOR_EN
  logic [6:0] cursor_col = '0;
  logic [5:0] cursor_row = '0;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  logic [7:0] tram_mem [0:4095];
  logic [7:0] rom_mem  [0:2047];

  text_pixel_gen_if mem_if ();

  // Memories hand back the word for the address registered on the previous pix_ce
  assign mem_if.tram_data = tram_mem[mem_if.tram_addr];
  assign mem_if.rom_dout  = rom_mem[mem_if.rom_ad];

  always #5 clk = ~clk;

  text_pixel_gen #(.COLS(80), .ROWS(40), .CELL_H(12), .FONT_H(9)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pix_ce (pix_ce),
    .de_in  (de_in),
    .hs_in  (hs_in),
    .vs_in  (vs_in),
    .hcount (hcount),
    .mem    (mem_if),
    .pix    (pix),
    .de_out (de_out),
    .hs_out (hs_out),
    .vs_out (vs_out)
`ifdef TEXT_CURSOR_EN
    ,
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One short scanline: 8 active pixels (col 0), 4 blanking steps, hs on step 8.
  // Outputs after step j show step j-3. Optional 3-cycle pix_ce stall after step stall_at.
  task automatic run_line(input string tag, input logic [7:0] pat, input bit do_chk,
                          input int stall_at, input logic [10:0] exp_rom);
    int k;
    for (int j = 0; j < 12; j++) begin
      pix_ce = 1'b1;
      de_in  = (j < 8);
      hcount = (j < 8) ? 10'(j) : 10'd0;
      hs_in  = (j == 8);
      vs_in  = 1'b0;
      tick();
      k = j - 3;
      if (do_chk && k >= 0) begin
        chk({tag, ".pix"}, pix, (k < 8) ? pat[7-k] : 1'b0);
        chk({tag, ".de"},  de_out, (k < 8));
        chk({tag, ".hs"},  hs_out, (k == 8));
        chk({tag, ".vs"},  vs_out, 0);
      end
      if (j == stall_at && k >= 0) begin
        pix_ce = 1'b0;
        de_in  = 1'b0;
        hcount = '1;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk({tag, ".stall.pix"},  pix, pat[7-k]);
          chk({tag, ".stall.de"},   de_out, 1);
          chk({tag, ".stall.hs"},   hs_out, 0);
          chk({tag, ".stall.addr"}, mem_if.tram_addr, 0);
          chk({tag, ".stall.rom"},  mem_if.rom_ad, exp_rom);
        end
      end
    end
  endtask

  task automatic blank_lines(input int n);
    for (int i = 0; i < n; i++) run_line("blank", 8'h00, 1'b0, -1, 11'd0);
  endtask

  task automatic vs_pulse(input bit do_chk);
    for (int j = 0; j < 4; j++) begin
      pix_ce = 1'b1;
      de_in  = 1'b0;
      hs_in  = 1'b0;
      vs_in  = (j == 0);
      hcount = '0;
      tick();
      if (do_chk && j == 2) chk("vs.early", vs_out, 0);
      if (do_chk && j == 3) chk("vs.delay", vs_out, 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) tram_mem[i] = '0;
    for (int i = 0; i < 2048; i++) rom_mem[i]  = '0;
    tram_mem[0]    = 8'h41;
    tram_mem[83]   = 8'hA3;
    tram_mem[3200] = 8'hC1;
    rom_mem[{4'd2,  7'h41}] = 8'hA5;
    rom_mem[{4'd10, 7'h41}] = 8'hFF;

    // reset with active-looking inputs
    resetn = 1'b0;
    pix_ce = 1'b1; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; hcount = 10'd9;
    repeat (3) tick();
    chk("rst.pix",  pix, 0);
    chk("rst.de",   de_out, 0);
    chk("rst.hs",   hs_out, 0);
    chk("rst.vs",   vs_out, 0);
    chk("rst.addr", mem_if.tram_addr, 0);
    chk("rst.rom",  mem_if.rom_ad, 0);
    chk("rom_ce",   mem_if.rom_ce, 1);
    resetn = 1'b1;

    // frame 1: plain glyph
    vs_pulse(1'b1);
    run_line("f1.l0", 8'h00, 1'b1, -1, 11'd0);
    blank_lines(1);
    run_line("f1.l2", 8'hA5, 1'b1, -1, 11'd0);
    blank_lines(7);
    run_line("f1.l10", 8'h00, 1'b1, -1, 11'd0);
    blank_lines(1);
    // line 12: text row 1, cell line 0, col 3
    pix_ce = 1'b1; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0; hcount = 10'd24;
    tick();
    chk("l12.addr", mem_if.tram_addr, 83);
    tick();
    chk("l12.rom", mem_if.rom_ad, 11'h023);
    chk("l12.rom.row", mem_if.rom_ad[10:7], 0);
    // vs coincides with the de falling edge here
    vs_pulse(1'b1);

    // frame 2: inverted glyph, row saturation
    tram_mem[0] = 8'hC1;
    run_line("f2.l0", 8'hFF, 1'b1, -1, 11'd0);
    blank_lines(1);
    run_line("f2.l2", 8'h5A, 1'b1, -1, 11'd0);
    blank_lines(7);
    run_line("f2.l10", 8'hFF, 1'b1, -1, 11'd0);
    blank_lines(469);
    run_line("f2.l480", 8'h00, 1'b1, -1, 11'd0);

    // frame 3: pix_ce stall mid-line
    tram_mem[0] = 8'h41;
    vs_pulse(1'b0);
    blank_lines(2);
    run_line("f3.stall", 8'hA5, 1'b1, 4, 11'h141);

    // frame 4: reset mid-line
    vs_pulse(1'b0);
    blank_lines(2);
    for (int j = 0; j < 6; j++) begin
      pix_ce = 1'b1; de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0; hcount = 10'(j);
      tick();
    end
    chk("mid.pre.pix", pix, 1);
    chk("mid.pre.de",  de_out, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid.rst.pix", pix, 0);
    chk("mid.rst.de",  de_out, 0);
    chk("mid.rst.hs",  hs_out, 0);
    chk("mid.rst.vs",  vs_out, 0);
    hcount = 10'd6; tick();
    hcount = 10'd7; tick();
    resetn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      de_in = 1'b1; hcount = 10'(r);
      tick();
      chk("mid.rel.pix", pix, 0);
      chk("mid.rel.de",  de_out, (r == 3));
    end
    de_in = 1'b0; hcount = '0;
    repeat (4) tick();

`ifdef TEXT_CURSOR_EN
    // blink phase on after 16 frames
    repeat (15) vs_pulse(1'b0);
    vs_pulse(1'b1);
    blank_lines(10);
    run_line("cur.l10", 8'hFF, 1'b1, -1, 11'd0);
    run_line("cur.l11", 8'hFF, 1'b1, -1, 11'd0);
    // off again after 32
    repeat (16) vs_pulse(1'b0);
    blank_lines(10);
    run_line("cur.off.l10", 8'h00, 1'b1, -1, 11'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
